// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame-buffer swap controller: fills the back buffer from a
// host pixel stream and swaps front/back only on a display frame boundary.
module fb_swap_ctrl #(
  parameter int unsigned N_ROWS_MAX  = 64,
  parameter int unsigned N_COLS_MAX  = 256,
  parameter int unsigned PIXEL_WIDTH = 24,
  localparam int unsigned ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX)
) (
  input  logic                   clk,
  input  logic                   ctrl_rst_n,
  input  logic                   ctrl_en,
  input  logic [31:0]            ctrl_n_rows,
  input  logic [31:0]            ctrl_n_cols,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_last,
  input  logic                   disp_frame_done,
  output logic                   disp_buffer,
  output logic                   wmem_en,
  output logic                   wmem_we,
  output logic                   wmem_buffer,
  output logic [ADDR_WIDTH-1:0]  wmem_addr,
  output logic [PIXEL_WIDTH-1:0] wmem_data,
  output logic                   swap_done,
  output logic [15:0]            frame_cnt,
  output logic                   err_len
);

  typedef enum logic [1:0] {FILL, PENDING, SWAP} state_t;

  state_t      state;
  logic [1:0]  rst_sync;
  logic [31:0] wr_ptr;
  logic [31:0] frame_pix;
  logic        run;
  logic        accept;
  logic        in_range;
  logic        is_last_pix;

  // Reset release synchronizer; nothing is accepted until it has filled
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run         = rst_sync[1] & ctrl_en;
  assign frame_pix   = ctrl_n_rows * ctrl_n_cols;
  assign s_ready     = run && (state == FILL);
  assign accept      = s_valid & s_ready;
  assign in_range    = wr_ptr < frame_pix;
  assign is_last_pix = wr_ptr == (frame_pix - 32'd1);

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state       <= FILL;
      wr_ptr      <= '0;
      disp_buffer <= 1'b0;
      wmem_en     <= 1'b0;
      wmem_we     <= 1'b0;
      wmem_buffer <= 1'b0;
      wmem_addr   <= '0;
      wmem_data   <= '0;
      swap_done   <= 1'b0;
      frame_cnt   <= '0;
      err_len     <= 1'b0;
    end else begin
      wmem_en   <= 1'b0;
      wmem_we   <= 1'b0;
      swap_done <= 1'b0;
      if (accept) begin
        // Beats past the frame end are dropped but still flag the length error
        if (in_range) begin
          wmem_en     <= 1'b1;
          wmem_we     <= 1'b1;
          wmem_buffer <= ~disp_buffer;
          wmem_addr   <= wr_ptr[ADDR_WIDTH-1:0];
          wmem_data   <= s_data;
        end
        if (!in_range || (s_last && !is_last_pix)) err_len <= 1'b1;
        if (s_last) begin
          wr_ptr <= '0;
          state  <= PENDING;
        end else if (in_range) begin
          wr_ptr <= wr_ptr + 32'd1;
        end
      end else if (run) begin
        case (state)
          PENDING: begin
            if (disp_frame_done) begin
              state       <= SWAP;
              disp_buffer <= ~disp_buffer;
              swap_done   <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
            end
          end
          SWAP:    state <= FILL;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL have parameter N_ROWS_MAX, default 64, max panel rows.
REQ-002 SHALL have parameter N_COLS_MAX, default 256, max chained columns.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 24, bits per pixel.
REQ-004 SHALL have derived parameter ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX); it is not to be overridden.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port ctrl_rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port ctrl_en, input, 1, enable.
REQ-008 SHALL have ports ctrl_n_rows and ctrl_n_cols, input, 32 each, active geometry; unsigned, not latched.
REQ-009 SHALL have ports s_valid, s_ready, s_data[PIXEL_WIDTH-1:0] and s_last (in, out, in, in), host pixel stream, row-major.
REQ-010 SHALL have port disp_frame_done, input, 1, display finished last row/bit of a frame; single-cycle pulse.
REQ-011 SHALL have port disp_buffer, output, 1, front buffer index driven to the display reader.
REQ-012 SHALL have ports wmem_en, wmem_we, wmem_buffer, wmem_addr[ADDR_WIDTH-1:0] and wmem_data[PIXEL_WIDTH-1:0], all outputs, frame-buffer write port.
REQ-013 SHALL have port swap_done, output, 1, one-cycle pulse per buffer swap.
REQ-014 SHALL have port frame_cnt, output, 16, completed swaps; wraps.
REQ-015 SHALL have port err_len, output, 1, sticky frame-length error.

Function
REQ-016 SHALL implement states FILL, PENDING, SWAP.
REQ-017 In FILL with ctrl_en=1, SHALL drive s_ready=1.
REQ-018 SHALL drive s_ready=0 in PENDING, in SWAP, and whenever ctrl_en=0.
REQ-019 On each accepted beat (s_valid&s_ready), the next cycle SHALL drive wmem_en=wmem_we=1, wmem_buffer=~disp_buffer, wmem_addr=wr_ptr, wmem_data=s_data; write latency is exactly 1 cycle.
REQ-020 Write strobes SHALL be 0 in every cycle not following an accepted beat.
REQ-021 FRAME_PIX = ctrl_n_rows*ctrl_n_cols, computed in 32 bits; wr_ptr SHALL increment by 1 per accepted beat, starting at 0.
REQ-022 Accepted beat with s_last=1 SHALL move FILL->PENDING and clear wr_ptr to 0.
REQ-023 If s_last=1 arrives with wr_ptr != FRAME_PIX-1, err_len SHALL be set; the write is still performed and the frame still goes PENDING.
REQ-024 Accepted beats with wr_ptr >= FRAME_PIX SHALL set err_len and SHALL NOT assert wmem_en; wr_ptr saturates at FRAME_PIX.
REQ-025 In PENDING, disp_frame_done=1 SHALL move to SWAP.
REQ-026 In SWAP (one cycle), disp_buffer SHALL toggle, swap_done SHALL pulse high in that cycle, frame_cnt SHALL increment modulo 2^16, and the next state SHALL be FILL.
REQ-027 disp_frame_done in FILL SHALL be ignored, including the cycle in which s_last is accepted; the swap waits for the next pulse.
REQ-028 disp_buffer SHALL change only in SWAP, so the display never sees a partially written front buffer.
REQ-029 ctrl_en=0 SHALL freeze the state, wr_ptr and disp_buffer.
REQ-030 ctrl_en=0 SHALL NOT mask the write for a beat accepted in the previous cycle.
REQ-031 err_len SHALL clear only on reset.

Reset
REQ-032 Asserting ctrl_rst_n=0 SHALL immediately (asynchronously) force: state FILL, wr_ptr 0, disp_buffer 0, s_ready 0, wmem_en 0, wmem_we 0, wmem_buffer 0, wmem_addr 0, wmem_data 0, swap_done 0, frame_cnt 0, err_len 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, writing SHALL restart at address 0 of buffer 1.
REQ-034 Reset release SHALL be synchronized so that s_ready first rises no earlier than the second clk edge after deassertion.

Verification
REQ-035 SHALL verify normal frame: rows=2, cols=4, 8 beats with s_last on the 8th -> writes at addr 0..7 with buffer 1; disp_frame_done -> 1 cycle later disp_buffer=1, swap_done pulses, frame_cnt=1.
REQ-036 SHALL verify early last: 2x4 geometry, s_last on beat 5 -> err_len=1, PENDING entered, s_ready=0 until swap.
REQ-037 SHALL verify overflow: 2x4 geometry, 10 beats with s_last on the 10th -> beats 9-10 produce no wmem_en, err_len=1.
REQ-038 SHALL verify a simultaneous event: s_last accepted in the same cycle as disp_frame_done -> no swap; the next disp_frame_done swaps.
REQ-039 SHALL verify reset mid-frame: ctrl_rst_n low after 3 beats -> all outputs at reset values without a clock edge; the next frame writes addr 0 in buffer 1.
REQ-040 SHALL verify wrap: 65536 swaps -> frame_cnt=0 and disp_buffer=0.
